// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches under a credit limit,
// buffers tagged responses in a prefetch FIFO and handles decode stalls and redirects.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        id_ready,
  output logic [31:0] Instruction,
  output logic [63:0] PC_Out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t      fifo_mem  [DEPTH];
  logic [63:0] shadow_pc [DEPTH];

  logic [63:0]   pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] sh_rd_ptr, sh_wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill_cnt;

  logic   credit_ok;
  logic   req_fire;
  logic   resp_take;
  logic   push;
  logic   pop;
  entry_t head;

  // A response with nothing outstanding (e.g. a late word from before reset) carries no tag
  // and is discarded without touching any counter.
  always_comb begin
    credit_ok      = (SW'(outstanding) + SW'(count)) < SW'(DEPTH);
    imem_req_valid = !reset && !redirect_valid && credit_ok;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_take      = imem_resp_valid && (outstanding != '0);
    push           = resp_take && (kill_cnt == '0) && !redirect_valid;
    fetch_valid    = !reset && (count != '0);
    pop            = fetch_valid && id_ready && !redirect_valid;
    head           = fifo_mem[rd_ptr];
    Instruction    = fetch_valid ? head.instr : '0;
    PC_Out         = fetch_valid ? head.pc    : '0;
  end

  // NOTE: state registers use non-blocking assignments so every update in this block
  // sees the pre-edge values of pc, count and outstanding, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sh_rd_ptr   <= '0;
      sh_wr_ptr   <= '0;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
      if (req_fire)  sh_wr_ptr <= sh_wr_ptr + PW'(1);
      if (resp_take) sh_rd_ptr <= sh_rd_ptr + PW'(1);

      if (redirect_valid) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        pc       <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        kill_cnt <= outstanding - CW'(resp_take);
      end else begin
        if (req_fire) pc     <= pc + 64'd4;
        if (push)     wr_ptr <= wr_ptr + PW'(1);
        if (pop)      rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (resp_take && (kill_cnt != '0)) kill_cnt <= kill_cnt - CW'(1);
      end
    end
  end

  // NOTE: the FIFO and shadow storage are not reset; validity is tracked solely by
  // count/outstanding, so clearing the arrays would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push)     fifo_mem[wr_ptr]     <= '{instr: imem_resp_data, pc: shadow_pc[sh_rd_ptr]};
    if (req_fire) shadow_pc[sh_wr_ptr] <= pc;
  end

endmodule
